reg_rename_file: RTL and testbench
==================================

Name: reg_rename_file

Overview:
- Parametrised architectural register file with per-register rename status (busy bit plus ROB tag).
- Serves a superscalar issue bundle: multiple source reads, multiple destination claims and multiple ROB commits per cycle.
- Resolves operands through three sources:
  - intra-bundle dependencies,
  - same-cycle commit bypass,
  - ROB value lookup.
- Sits between decoder/issue, ROB and reservation stations; rob_clear_up drops all rename state on mispredict.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural register count (power of two; index width RIDX = log2(NREG)).
- ROB_BIT, 4, ROB tag width.
- ISSUE_W, 2, issue slots per cycle; slot 0 is oldest.
- COMMIT_W, 2, commit ports per cycle; port 0 is oldest.
- SRC_PER_SLOT, 2, source reads per issue slot; NRD = ISSUE_W*SRC_PER_SLOT.

Ports:
- clk_in, in, 1, system clock.
- rst_in, in, 1, asynchronous active-low reset.
- rdy_in, in, 1, state holds when low.
- rob_clear_up, in, 1, flush all rename state.
- commit_valid, in, COMMIT_W, per-port commit strobe.
- commit_reg_id, in, COMMIT_W*RIDX, destination register.
- commit_data, in, COMMIT_W*XLEN, result.
- commit_rob_entry, in, COMMIT_W*ROB_BIT, committing ROB tag.
- issue_valid, in, ISSUE_W, slot claims a destination.
- issue_reg_id, in, ISSUE_W*RIDX, destination register.
- issue_rob_entry, in, ISSUE_W*ROB_BIT, tag allocated to the slot.
- rd_id, in, NRD*RIDX, source register; port p belongs to slot p/SRC_PER_SLOT.
- rd_val, out, NRD*XLEN, operand value.
- rd_has_dep, out, NRD, operand not yet available.
- rd_dep, out, NRD*ROB_BIT, producing tag when rd_has_dep=1, else 0.
- rob_query_entry, out, NRD*ROB_BIT, tag sent to the ROB lookup.
- rob_query_ready, in, NRD, ROB has that tag's result.
- rob_query_value, in, NRD*XLEN, ROB result.

Behaviour:
- Storage: regs[NREG], busy[NREG], tag[NREG]. Reg 0 is hardwired: never written, never busy.
- Reset (rst_in=0, async): all regs, busy and tag = 0. All outputs are combinational, so they reflect the zeroed state immediately (rd_val=0, rd_has_dep=0, rd_dep=0).
- Read resolution (combinational, zero latency): for each port p, reading reg r, owned by slot s, the first matching rule applies.
  1. r==0: val=0, dep=0.
  2. Intra-bundle: the youngest slot k<s with issue_valid[k] and issue_reg_id[k]==r gives has_dep=1, dep=issue_rob_entry[k], val=0.
  3. busy[r], and some commit port has commit_valid, id==r and tag==tag[r]: val = that commit_data, has_dep=0.
  4. busy[r] and rob_query_ready[p]: val=rob_query_value[p], has_dep=0.
  5. busy[r]: has_dep=1, dep=tag[r], val=0.
  6. Otherwise: val=regs[r], has_dep=0.
- rob_query_entry[p] = tag[r] always. It is independent of has_dep and feeds no output path back into itself.
- Reads ignore rdy_in and rob_clear_up; the consumer qualifies them.
- Sequential update on posedge clk_in, only when rdy_in=1.
  - Commit: for every valid port with id!=0, regs[id] <= data. On same-register conflict, the highest-index (youngest) port wins.
  - Commit clear: busy[id] and tag[id] are cleared if tag[id]==commit_rob_entry and no issue slot claims id this cycle.
  - Issue (suppressed when rob_clear_up=1): for every valid slot with id!=0, busy <= 1 and tag <= issue_rob_entry. On same-register conflict, the highest-index slot wins. Issue overrides commit-clear on the same register.
  - Flush: rob_clear_up=1 clears all busy/tag. Commits in the same cycle still write regs, since committed state is architectural.
- rdy_in=0: nothing changes; outputs still track current state and inputs.
- Illegal conditions, flagged by simulation-only assertions, never altering RTL behaviour:
  - commit to a non-busy reg whose tag does not match;
  - duplicate issue tags in one bundle.

Test Plan:
- Reset then read: rst_in low mid-run with x5=0x1234 and busy → all rd_val=0, rd_has_dep=0; after release, commit x5=0xAB → next cycle rd_id=5 gives val 0xAB.
- Rename/forward: slot0 issues x3 tag 2; next cycle read x3 with rob_query_ready=0 → has_dep=1, dep=2; with rob_query_ready=1, value 0x77 → val 0x77, has_dep=0.
- Intra-bundle: slot0 claims x4 tag 6, slot1 reads x4 the same cycle → slot1 port has_dep=1, dep=6; slot0's own read of x4 returns the old regs/tag value.
- Commit/issue race: x7 busy tag 1; same cycle commit x7 tag 1 data 0x9 and issue x7 tag 3 → regs[7]=0x9, busy=1, tag=3. Stale commit (tag 1 while tag[7]=3) → busy stays 1.
- Dual conflict: both commit ports write x9 (0x10, 0x20) → regs[9]=0x20. Both issue slots claim x9 (tags 4, 5) → tag[9]=5.
- Flush and x0: rob_clear_up with commit x2=0x55 and issue x8 → regs[2]=0x55, all busy=0, x8 not busy. Issue/commit to x0 → read x0 stays 0, has_dep=0. rdy_in=0 with a commit → no state change.

Source files
------------

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename status for a superscalar core.
//
// Each architectural register carries a busy bit and the ROB tag of its pending producer.
// Operand reads resolve combinationally in this priority order:
//   x0, then older slots in the same issue bundle, then a same-cycle commit,
//   then the ROB lookup, then the pending tag, and finally the committed value.
//
// Ports
//   clk_in, rst_in       clock, asynchronous active-low reset
//   rdy_in               state update enable (reads are unaffected)
//   rob_clear_up         drop all rename state (mispredict)
//   commit_*             COMMIT_W commit ports, port 0 oldest
//   issue_*              ISSUE_W destination claims, slot 0 oldest
//   rd_id                NRD source register ids, port p belongs to slot p/SRC_PER_SLOT
//   rd_val/has_dep/dep   resolved operand, or the tag it still waits on
//   rob_query_*          per-port ROB value lookup keyed by the register's current tag
module reg_rename_file #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NREG         = 32,
  parameter int unsigned ROB_BIT      = 4,
  parameter int unsigned ISSUE_W      = 2,
  parameter int unsigned COMMIT_W     = 2,
  parameter int unsigned SRC_PER_SLOT = 2,
  localparam int unsigned RIDX        = $clog2(NREG),
  localparam int unsigned NRD         = ISSUE_W * SRC_PER_SLOT
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        rob_clear_up,
  input  logic [COMMIT_W-1:0]         commit_valid,
  input  logic [COMMIT_W*RIDX-1:0]    commit_reg_id,
  input  logic [COMMIT_W*XLEN-1:0]    commit_data,
  input  logic [COMMIT_W*ROB_BIT-1:0] commit_rob_entry,
  input  logic [ISSUE_W-1:0]          issue_valid,
  input  logic [ISSUE_W*RIDX-1:0]     issue_reg_id,
  input  logic [ISSUE_W*ROB_BIT-1:0]  issue_rob_entry,
  input  logic [NRD*RIDX-1:0]         rd_id,
  output logic [NRD*XLEN-1:0]         rd_val,
  output logic [NRD-1:0]              rd_has_dep,
  output logic [NRD*ROB_BIT-1:0]      rd_dep,
  output logic [NRD*ROB_BIT-1:0]      rob_query_entry,
  input  logic [NRD-1:0]              rob_query_ready,
  input  logic [NRD*XLEN-1:0]         rob_query_value
);

  logic [XLEN-1:0]    r_regs [NREG];
  logic [NREG-1:0]    r_busy;
  logic [ROB_BIT-1:0] r_tag  [NREG];

  logic [XLEN-1:0]    w_regs_d [NREG];
  logic [NREG-1:0]    w_busy_d;
  logic [ROB_BIT-1:0] w_tag_d  [NREG];

  // Operand resolution
  always_comb begin : p_read
    logic [RIDX-1:0]    rid;
    int unsigned        slot;
    logic               intra_hit;
    logic [ROB_BIT-1:0] intra_tag;
    logic               cmt_hit;
    logic [XLEN-1:0]    cmt_data;
    rd_val          = '0;
    rd_has_dep      = '0;
    rd_dep          = '0;
    rob_query_entry = '0;
    rid             = '0;
    slot            = 0;
    intra_hit       = 1'b0;
    intra_tag       = '0;
    cmt_hit         = 1'b0;
    cmt_data        = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      rid  = rd_id[p*RIDX +: RIDX];
      slot = p / SRC_PER_SLOT;
      rob_query_entry[p*ROB_BIT +: ROB_BIT] = r_tag[rid];

      // Ascending scan so the youngest older slot wins.
      intra_hit = 1'b0;
      intra_tag = '0;
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
        if (k < slot && issue_valid[k] && issue_reg_id[k*RIDX +: RIDX] == rid) begin
          intra_hit = 1'b1;
          intra_tag = issue_rob_entry[k*ROB_BIT +: ROB_BIT];
        end
      end

      // Commit bypass only when the committing tag is the register's live producer.
      cmt_hit  = 1'b0;
      cmt_data = '0;
      for (int unsigned c = 0; c < COMMIT_W; c++) begin
        if (commit_valid[c] && commit_reg_id[c*RIDX +: RIDX] == rid &&
            commit_rob_entry[c*ROB_BIT +: ROB_BIT] == r_tag[rid]) begin
          cmt_hit  = 1'b1;
          cmt_data = commit_data[c*XLEN +: XLEN];
        end
      end

      if (rid != '0) begin
        if (intra_hit) begin
          rd_has_dep[p]                = 1'b1;
          rd_dep[p*ROB_BIT +: ROB_BIT] = intra_tag;
        end else if (r_busy[rid] && cmt_hit) begin
          rd_val[p*XLEN +: XLEN] = cmt_data;
        end else if (r_busy[rid] && rob_query_ready[p]) begin
          rd_val[p*XLEN +: XLEN] = rob_query_value[p*XLEN +: XLEN];
        end else if (r_busy[rid]) begin
          rd_has_dep[p]                = 1'b1;
          rd_dep[p*ROB_BIT +: ROB_BIT] = r_tag[rid];
        end else begin
          rd_val[p*XLEN +: XLEN] = r_regs[rid];
        end
      end
    end
  end

  // Next state: commits first, then flush or issue so a new claim overrides a clear.
  always_comb begin : p_next
    logic [RIDX-1:0] id;
    logic            claimed;
    w_regs_d = r_regs;
    w_busy_d = r_busy;
    w_tag_d  = r_tag;
    id       = '0;
    claimed  = 1'b0;
    for (int unsigned c = 0; c < COMMIT_W; c++) begin
      id = commit_reg_id[c*RIDX +: RIDX];
      if (commit_valid[c] && id != '0) begin
        w_regs_d[id] = commit_data[c*XLEN +: XLEN];
        claimed = 1'b0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
          if (issue_valid[k] && issue_reg_id[k*RIDX +: RIDX] == id) claimed = 1'b1;
        end
        if (!claimed && r_tag[id] == commit_rob_entry[c*ROB_BIT +: ROB_BIT]) begin
          w_busy_d[id] = 1'b0;
          w_tag_d[id]  = '0;
        end
      end
    end
    if (rob_clear_up) begin
      w_busy_d = '0;
      for (int unsigned i = 0; i < NREG; i++) w_tag_d[i] = '0;
    end else begin
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
        id = issue_reg_id[k*RIDX +: RIDX];
        if (issue_valid[k] && id != '0) begin
          w_busy_d[id] = 1'b1;
          w_tag_d[id]  = issue_rob_entry[k*ROB_BIT +: ROB_BIT];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin : p_state
    if (!rst_in) begin
      r_busy <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (rdy_in) begin
      r_busy <= w_busy_d;
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= w_regs_d[i];
        r_tag[i]  <= w_tag_d[i];
      end
    end
  end

`ifndef SYNTHESIS
  // Protocol checks only; they never affect the datapath.
  always_ff @(posedge clk_in) begin : p_protocol_chk
    if (rst_in && rdy_in) begin
      for (int unsigned c = 0; c < COMMIT_W; c++) begin
        if (commit_valid[c] && commit_reg_id[c*RIDX +: RIDX] != '0) begin
          assert (r_busy[commit_reg_id[c*RIDX +: RIDX]] ||
                  r_tag[commit_reg_id[c*RIDX +: RIDX]] == commit_rob_entry[c*ROB_BIT +: ROB_BIT])
            else $error("commit to idle register %0d with foreign tag",
                        commit_reg_id[c*RIDX +: RIDX]);
        end
      end
      if (!rob_clear_up) begin
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
          for (int unsigned j = i + 1; j < ISSUE_W; j++) begin
            assert (!(issue_valid[i] && issue_valid[j] &&
                      issue_rob_entry[i*ROB_BIT +: ROB_BIT] ==
                      issue_rob_entry[j*ROB_BIT +: ROB_BIT]))
              else $error("duplicate issue tag in slots %0d and %0d", i, j);
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_rename_file.sv
module tb_reg_rename_file;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RB   = 4;
  localparam int RIDX = 5;
  localparam int IW   = 2;
  localparam int CW   = 2;
  localparam int SPS  = 2;
  localparam int NRD  = IW * SPS;

  logic                 clk_in;
  logic                 rst_in;
  logic                 rdy_in;
  logic                 rob_clear_up;
  logic [CW-1:0]        commit_valid;
  logic [CW*RIDX-1:0]   commit_reg_id;
  logic [CW*XLEN-1:0]   commit_data;
  logic [CW*RB-1:0]     commit_rob_entry;
  logic [IW-1:0]        issue_valid;
  logic [IW*RIDX-1:0]   issue_reg_id;
  logic [IW*RB-1:0]     issue_rob_entry;
  logic [NRD*RIDX-1:0]  rd_id;
  logic [NRD*XLEN-1:0]  rd_val;
  logic [NRD-1:0]       rd_has_dep;
  logic [NRD*RB-1:0]    rd_dep;
  logic [NRD*RB-1:0]    rob_query_entry;
  logic [NRD-1:0]       rob_query_ready;
  logic [NRD*XLEN-1:0]  rob_query_value;

  reg_rename_file dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .rob_clear_up     (rob_clear_up),
    .commit_valid     (commit_valid),
    .commit_reg_id    (commit_reg_id),
    .commit_data      (commit_data),
    .commit_rob_entry (commit_rob_entry),
    .issue_valid      (issue_valid),
    .issue_reg_id     (issue_reg_id),
    .issue_rob_entry  (issue_rob_entry),
    .rd_id            (rd_id),
    .rd_val           (rd_val),
    .rd_has_dep       (rd_has_dep),
    .rd_dep           (rd_dep),
    .rob_query_entry  (rob_query_entry),
    .rob_query_ready  (rob_query_ready),
    .rob_query_value  (rob_query_value)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference state: what the architecture holds after each accepted clock.
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  logic [RB-1:0]   m_tag  [NREG];

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] g_val(input int p);
    return rd_val[p*XLEN +: XLEN];
  endfunction
  function automatic logic [31:0] g_hd(input int p);
    return 32'(rd_has_dep[p]);
  endfunction
  function automatic logic [31:0] g_dep(input int p);
    return 32'(rd_dep[p*RB +: RB]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  // Architectural effect of one accepted clock edge, using the inputs held at that edge.
  task automatic model_clock();
    logic [RB-1:0] old_tag [NREG];
    int id;
    bit claimed;
    if (!rdy_in) return;
    for (int i = 0; i < NREG; i++) old_tag[i] = m_tag[i];
    for (int c = 0; c < CW; c++) begin
      id = int'(commit_reg_id[c*RIDX +: RIDX]);
      if (commit_valid[c] && id != 0) begin
        m_regs[id] = commit_data[c*XLEN +: XLEN];
        claimed = 1'b0;
        for (int k = 0; k < IW; k++)
          if (issue_valid[k] && int'(issue_reg_id[k*RIDX +: RIDX]) == id) claimed = 1'b1;
        if (!claimed && old_tag[id] == commit_rob_entry[c*RB +: RB]) begin
          m_busy[id] = 1'b0;
          m_tag[id]  = '0;
        end
      end
    end
    if (rob_clear_up) begin
      for (int i = 0; i < NREG; i++) begin
        m_busy[i] = 1'b0;
        m_tag[i]  = '0;
      end
    end else begin
      for (int k = 0; k < IW; k++) begin
        id = int'(issue_reg_id[k*RIDX +: RIDX]);
        if (issue_valid[k] && id != 0) begin
          m_busy[id] = 1'b1;
          m_tag[id]  = issue_rob_entry[k*RB +: RB];
        end
      end
    end
  endtask

  // First-match operand rules evaluated on the reference state and the live inputs.
  function automatic void exp_read(input int p, output logic [31:0] v, output logic hd,
                                   output logic [RB-1:0] dep, output logic [RB-1:0] qe);
    int r;
    int s;
    r   = int'(rd_id[p*RIDX +: RIDX]);
    s   = p / SPS;
    v   = '0;
    hd  = 1'b0;
    dep = '0;
    qe  = m_tag[r];
    if (r == 0) return;
    for (int k = s - 1; k >= 0; k--) begin
      if (issue_valid[k] && int'(issue_reg_id[k*RIDX +: RIDX]) == r) begin
        hd  = 1'b1;
        dep = issue_rob_entry[k*RB +: RB];
        return;
      end
    end
    if (m_busy[r]) begin
      for (int c = CW - 1; c >= 0; c--) begin
        if (commit_valid[c] && int'(commit_reg_id[c*RIDX +: RIDX]) == r &&
            commit_rob_entry[c*RB +: RB] == m_tag[r]) begin
          v = commit_data[c*XLEN +: XLEN];
          return;
        end
      end
      if (rob_query_ready[p]) begin
        v = rob_query_value[p*XLEN +: XLEN];
        return;
      end
      hd  = 1'b1;
      dep = m_tag[r];
      return;
    end
    v = m_regs[r];
  endfunction

  task automatic check_reads(input string tag);
    logic [31:0]   v;
    logic          hd;
    logic [RB-1:0] dep;
    logic [RB-1:0] qe;
    for (int p = 0; p < NRD; p++) begin
      exp_read(p, v, hd, dep, qe);
      chk($sformatf("%s/p%0d/val", tag, p), g_val(p), v);
      chk($sformatf("%s/p%0d/has_dep", tag, p), g_hd(p), 32'(hd));
      chk($sformatf("%s/p%0d/dep", tag, p), g_dep(p), 32'(dep));
      chk($sformatf("%s/p%0d/qentry", tag, p), 32'(rob_query_entry[p*RB +: RB]), 32'(qe));
    end
  endtask

  task automatic clear_inputs();
    rdy_in           = 1'b1;
    rob_clear_up     = 1'b0;
    commit_valid     = '0;
    commit_reg_id    = '0;
    commit_data      = '0;
    commit_rob_entry = '0;
    issue_valid      = '0;
    issue_reg_id     = '0;
    issue_rob_entry  = '0;
    rd_id            = '0;
    rob_query_ready  = '0;
    rob_query_value  = '0;
  endtask

  task automatic set_commit(input int c, input int id, input logic [31:0] d, input int tg);
    commit_valid[c]              = 1'b1;
    commit_reg_id[c*RIDX +: RIDX] = RIDX'(id);
    commit_data[c*XLEN +: XLEN]   = d;
    commit_rob_entry[c*RB +: RB]  = RB'(tg);
  endtask

  task automatic set_issue(input int k, input int id, input int tg);
    issue_valid[k]               = 1'b1;
    issue_reg_id[k*RIDX +: RIDX] = RIDX'(id);
    issue_rob_entry[k*RB +: RB]  = RB'(tg);
  endtask

  task automatic set_read(input int p, input int id, input bit qr, input logic [31:0] qv);
    rd_id[p*RIDX +: RIDX]           = RIDX'(id);
    rob_query_ready[p]              = qr;
    rob_query_value[p*XLEN +: XLEN] = qv;
  endtask

  // Called at a falling edge once inputs are driven.
  task automatic settle(input string tag);
    #1;
    check_reads(tag);
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_clock();
    @(negedge clk_in);
    clear_inputs();
  endtask

  int id;
  int tg;
  int t0;
  int t1;

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_in = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk_in);
    settle("reset");
    chk("reset_val0", g_val(0), 32'h0);
    chk("reset_hd0", g_hd(0), 32'h0);
    rst_in = 1'b1;
    @(negedge clk_in);

    // x5 = 0x1234 and busy, then an asynchronous reset mid-cycle
    set_commit(0, 5, 32'h1234, 0);
    settle("load_x5"); tick();
    set_issue(0, 5, 3);
    settle("busy_x5"); tick();
    for (int p = 0; p < NRD; p++) set_read(p, 5, 1'b0, 32'h0);
    #2;
    rst_in = 1'b0;
    model_reset();
    #1;
    check_reads("rst_mid");
    chk("rst_mid_val", g_val(1), 32'h0);
    chk("rst_mid_hd", g_hd(1), 32'h0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    clear_inputs();

    set_commit(0, 5, 32'hAB, 0);
    set_commit(1, 4, 32'h44, 0);
    settle("commit_x5"); tick();
    set_read(0, 5, 1'b0, 32'h0);
    settle("read_x5");
    chk("x5_after_reset", g_val(0), 32'hAB);
    tick();

    // Rename and ROB forwarding
    set_issue(0, 3, 2);
    settle("issue_x3"); tick();
    set_read(0, 3, 1'b0, 32'h0);
    set_read(1, 3, 1'b1, 32'h77);
    settle("fwd_x3");
    chk("x3_hd", g_hd(0), 32'h1);
    chk("x3_dep", g_dep(0), 32'h2);
    chk("x3_rob_val", g_val(1), 32'h77);
    chk("x3_rob_hd", g_hd(1), 32'h0);
    tick();

    // Intra-bundle dependency
    set_issue(0, 4, 6);
    set_read(0, 4, 1'b0, 32'h0);
    set_read(2, 4, 1'b0, 32'h0);
    settle("intra");
    chk("intra_hd", g_hd(2), 32'h1);
    chk("intra_dep", g_dep(2), 32'h6);
    chk("intra_own_val", g_val(0), 32'h44);
    chk("intra_own_hd", g_hd(0), 32'h0);
    tick();

    // Commit and issue racing on the same register
    set_issue(0, 7, 1);
    settle("issue_x7"); tick();
    set_commit(0, 7, 32'h9, 1);
    set_issue(0, 7, 3);
    settle("race_x7"); tick();
    set_read(0, 7, 1'b0, 32'h0);
    rob_clear_up = 1'b1;
    settle("race_dep");
    chk("race_hd", g_hd(0), 32'h1);
    chk("race_tag", g_dep(0), 32'h3);
    tick();
    set_read(0, 7, 1'b0, 32'h0);
    settle("race_regs");
    chk("race_regs", g_val(0), 32'h9);
    tick();
    set_issue(0, 7, 3);
    settle("reissue_x7"); tick();
    set_commit(0, 7, 32'h5, 1);
    set_read(0, 7, 1'b0, 32'h0);
    settle("stale_same");
    chk("stale_same_hd", g_hd(0), 32'h1);
    tick();
    set_read(0, 7, 1'b0, 32'h0);
    settle("stale_after");
    chk("stale_hd", g_hd(0), 32'h1);
    chk("stale_tag", g_dep(0), 32'h3);
    tick();

    // Same-register conflicts between ports
    set_commit(0, 9, 32'h10, 0);
    set_commit(1, 9, 32'h20, 0);
    settle("dual_commit"); tick();
    set_read(0, 9, 1'b0, 32'h0);
    settle("dual_commit_rd");
    chk("dual_commit", g_val(0), 32'h20);
    tick();
    set_issue(0, 9, 4);
    set_issue(1, 9, 5);
    settle("dual_issue"); tick();
    set_read(0, 9, 1'b0, 32'h0);
    settle("dual_issue_rd");
    chk("dual_issue_tag", g_dep(0), 32'h5);
    tick();

    // Flush with a concurrent commit and issue
    set_issue(0, 8, 7);
    settle("issue_x8"); tick();
    rob_clear_up = 1'b1;
    set_commit(0, 2, 32'h55, 0);
    set_issue(0, 8, 8);
    settle("flush"); tick();
    set_read(0, 2, 1'b0, 32'h0);
    set_read(1, 8, 1'b0, 32'h0);
    set_read(2, 9, 1'b0, 32'h0);
    set_read(3, 7, 1'b0, 32'h0);
    settle("post_flush");
    chk("flush_x2", g_val(0), 32'h55);
    chk("flush_x8_hd", g_hd(1), 32'h0);
    chk("flush_x9_hd", g_hd(2), 32'h0);
    chk("flush_x7_hd", g_hd(3), 32'h0);
    tick();

    // x0 stays zero
    set_issue(0, 0, 1);
    set_commit(0, 0, 32'hFF, 0);
    set_read(2, 0, 1'b1, 32'h123);
    settle("x0_write");
    chk("x0_same_val", g_val(2), 32'h0);
    chk("x0_same_hd", g_hd(2), 32'h0);
    tick();
    set_read(0, 0, 1'b0, 32'h0);
    settle("x0_read");
    chk("x0_val", g_val(0), 32'h0);
    chk("x0_hd", g_hd(0), 32'h0);
    tick();

    // rdy_in low freezes state
    rdy_in = 1'b0;
    set_commit(0, 2, 32'h66, 0);
    set_issue(0, 10, 2);
    settle("stall"); tick();
    set_read(0, 2, 1'b0, 32'h0);
    set_read(1, 10, 1'b0, 32'h0);
    settle("post_stall");
    chk("stall_x2", g_val(0), 32'h55);
    chk("stall_x10_hd", g_hd(1), 32'h0);
    tick();

    // Randomised traffic over a small register window to force collisions
    for (int cyc = 0; cyc < 400; cyc++) begin
      rdy_in       = ($urandom_range(0, 9) != 0);
      rob_clear_up = ($urandom_range(0, 19) == 0);
      for (int c = 0; c < CW; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          id = int'($urandom_range(0, 7));
          if (m_busy[id]) tg = ($urandom_range(0, 3) != 0) ? int'(m_tag[id]) : int'($urandom_range(0, 15));
          else tg = 0;
          set_commit(c, id, $urandom, tg);
        end
      end
      t0 = int'($urandom_range(0, 15));
      t1 = t0 ^ int'($urandom_range(1, 15));
      if ($urandom_range(0, 4) < 3) set_issue(0, int'($urandom_range(0, 7)), t0);
      if ($urandom_range(0, 4) < 3) set_issue(1, int'($urandom_range(0, 7)), t1);
      for (int p = 0; p < NRD; p++)
        set_read(p, int'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), $urandom);
      settle("rand");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
